fft_mag_peak: RTL
=================

FFT_MAG_PEAK -- requirements
Module: fft_mag_peak

Interface
REQ-001 Parameter LOG_LEN, default 11, SHALL set log2 of the FFT length (bin index width).
REQ-002 Parameter IN_WIDTH, default 28, SHALL set the significant signed bits of each real and imaginary component.
REQ-003 Parameter PEAK_HI, default 1023, SHALL set the highest bin index that takes part in the peak search.
REQ-004 i_aclk  in  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-005 i_aresetn  in  1  SHALL be the reset, asynchronous assert and active-low.
REQ-006 i_fft_tvalid  in  1  SHALL mark a valid FFT output beat; there is no tready, so every valid beat SHALL be accepted.
REQ-007 i_fft_tdata  in  64  SHALL carry the real part in [IN_WIDTH-1:0] and the imaginary part in [32+IN_WIDTH-1:32]; the upper bits of each 32-bit lane are sign extension.
REQ-008 i_fft_tlast  in  1  SHALL mark the last beat of a frame.
REQ-009 i_fft_tuser  in  24  SHALL carry the bin index in [LOG_LEN-1:0]; the other bits SHALL be ignored.
REQ-010 o_mag_tvalid  out  1; o_mag_tdata  out  32; o_mag_tlast  out  1; o_mag_tuser  out  LOG_LEN  SHALL form the magnitude stream.
REQ-011 o_peak_valid  out  1; o_peak_bin  out  LOG_LEN; o_peak_mag  out  32  SHALL form the per-frame peak report.
REQ-012 o_frm_err  out  1  SHALL be a one-cycle pulse flagging a framing error.

Function
REQ-013 Magnitude SHALL be the alpha-max-beta-min estimate: mag = max + (min>>2) + (min>>3), where max/min are taken over |re| and |im|.
REQ-014 The |x| of the most negative input SHALL saturate to 2^(IN_WIDTH-1)-1.
REQ-015 mag SHALL be computed at IN_WIDTH+1 bits without truncation and zero-extended to 32 bits.
REQ-016 The datapath SHALL be a 3-stage pipeline:
  - S1: abs
  - S2: max/min
  - S3: sum
REQ-017 o_mag_* SHALL appear exactly 3 cycles after the matching input beat.
REQ-018 o_mag_tlast and o_mag_tuser SHALL be delayed in lockstep with o_mag_tvalid.
REQ-019 Input gaps (i_fft_tvalid low) SHALL propagate as gaps; no beat SHALL be dropped, duplicated or reordered.
REQ-020 The peak search SHALL run in two states, IDLE and SEARCH:
  - IDLE -> SEARCH on the first valid S3 beat.
  - SEARCH -> IDLE on the S3 beat that carries tlast.
REQ-021 On entering SEARCH, the running peak SHALL be cleared to mag=0, bin=0.
REQ-022 Only beats with 1 <= index <= PEAK_HI SHALL update the running peak.
REQ-023 The running peak SHALL update only when mag is strictly greater than the running value, so on a tie the lowest index wins.
REQ-024 One cycle after the S3 tlast beat:
  - o_peak_valid SHALL pulse high for exactly one cycle.
  - o_peak_bin and o_peak_mag SHALL present the peak, including any update made by the tlast beat itself.
REQ-025 o_peak_bin and o_peak_mag SHALL hold their values until the next report.
REQ-026 If no eligible beat occurred in a frame, the report SHALL be bin=0, mag=0.
REQ-027 o_frm_err SHALL pulse, aligned with the S3 beat, in each of these cases:
  - tlast arrives with index != 2^LOG_LEN-1;
  - index 2^LOG_LEN-1 arrives without tlast.
REQ-028 A frame in error SHALL still produce a peak report.
REQ-029 A tlast beat followed by a new frame's first beat on the next cycle SHALL be handled with no lost beat and a correct report for each frame.

Reset
REQ-030 While i_aresetn is low, all outputs and pipeline valid bits SHALL be 0 and the search state SHALL be IDLE.
REQ-031 A reset asserted mid-frame SHALL discard the partial frame with no peak report.
REQ-032 After reset deassertion, the first full frame SHALL report normally.
REQ-033 Pipeline data registers may be left unreset; valid, state and output registers SHALL be reset.

Structure
REQ-034 The shared package SHALL define:
  - the default LOG_LEN, IN_WIDTH and PEAK_HI;
  - the lane offsets (real at bit 0, imaginary at bit 32);
  - the state encoding IDLE/SEARCH.
REQ-035 There SHALL be one sub-module, fft_mag_est, holding the 3-stage magnitude pipeline; peak tracking and framing checks SHALL sit in the top level.

Verification
REQ-036 Single beat re=3000, im=-4000 -> mag 4000+750+375=5125 appears 3 cycles later.
REQ-037 Single beat re=-2^27, im=0 -> mag 2^27-1, with no sign wrap.
REQ-038 Frame of 2048 beats, all mag 0 except bin 100=5000 and bin 1500=9000 -> peak bin 100, mag 5000, one cycle after o_mag_tlast.
REQ-039 Frame with equal magnitudes at bins 7 and 300, plus a larger value at bin 0 -> peak bin 7 (bin 0 excluded, tie goes to the lower index).
REQ-040 Two frames back-to-back with no idle cycle, then tlast at index 1000 -> two correct reports, then o_frm_err pulses once and a report is still produced for the third frame.
REQ-041 i_aresetn pulsed low at beat 500 of a frame, then a full frame -> no report for the aborted frame, exactly one correct report for the full frame.

Source files
------------

// File: rtl/fft_mag_peak_pkg.sv
// -----------------------------------------------------------------------------
// fft_mag_peak_pkg
// Shared definitions for the FFT magnitude / peak-search block:
//   - default LOG_LEN, IN_WIDTH and PEAK_HI
//   - bit offsets of the real and imaginary lanes inside the 64-bit FFT beat
//   - peak-search state encoding
// -----------------------------------------------------------------------------
package fft_mag_peak_pkg;

    localparam int DEF_LOG_LEN  = 11;
    localparam int DEF_IN_WIDTH = 28;
    localparam int DEF_PEAK_HI  = 1023;

    // Each component sits in its own 32-bit lane, sign-extended above IN_WIDTH.
    localparam int RE_LSB = 0;
    localparam int IM_LSB = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

endpackage

// File: rtl/fft_mag_peak_if.sv
// -----------------------------------------------------------------------------
// fft_mag_peak_if
// Bundles the FFT input stream, the magnitude output stream, the per-frame
// peak report and the framing-error pulse.
//   master : drives the i_fft_* stream, observes all o_* outputs
//   slave  : the fft_mag_peak block
// Handshake: streams are valid-only (no tready). A beat transfers on every
// rising clock edge where its tvalid is high; the receiver must accept it.
// tdata/tlast/tuser are meaningful only while tvalid is high.
// -----------------------------------------------------------------------------
interface fft_mag_peak_if
    import fft_mag_peak_pkg::*;
#(
    parameter int LOG_LEN = DEF_LOG_LEN
);
    logic               i_fft_tvalid;
    logic [63:0]        i_fft_tdata;
    logic               i_fft_tlast;
    logic [23:0]        i_fft_tuser;

    logic               o_mag_tvalid;
    logic [31:0]        o_mag_tdata;
    logic               o_mag_tlast;
    logic [LOG_LEN-1:0] o_mag_tuser;

    logic               o_peak_valid;
    logic [LOG_LEN-1:0] o_peak_bin;
    logic [31:0]        o_peak_mag;

    logic               o_frm_err;

    modport master (
        output i_fft_tvalid, i_fft_tdata, i_fft_tlast, i_fft_tuser,
        input  o_mag_tvalid, o_mag_tdata, o_mag_tlast, o_mag_tuser,
        input  o_peak_valid, o_peak_bin, o_peak_mag, o_frm_err
    );

    modport slave (
        input  i_fft_tvalid, i_fft_tdata, i_fft_tlast, i_fft_tuser,
        output o_mag_tvalid, o_mag_tdata, o_mag_tlast, o_mag_tuser,
        output o_peak_valid, o_peak_bin, o_peak_mag, o_frm_err
    );

endinterface

// File: rtl/fft_mag_est.sv
// -----------------------------------------------------------------------------
// fft_mag_est
// Three-stage alpha-max-beta-min magnitude pipeline:
//   S1: saturating |re|, |im|
//   S2: max / min
//   S3: mag = max + (min>>2) + (min>>3), IN_WIDTH+1 bits, zero-extended to 32
// Sideband (tlast, bin index) travels in lockstep with tvalid.
// Ports:
//   i_aclk, i_aresetn               clock, async active-low reset
//   i_tvalid/i_tdata/i_tlast/i_tuser input beat (tuser = bin index)
//   o_tvalid/o_tdata/o_tlast/o_tuser magnitude beat, 3 cycles later
// -----------------------------------------------------------------------------
module fft_mag_est
    import fft_mag_peak_pkg::*;
#(
    parameter int LOG_LEN  = DEF_LOG_LEN,
    parameter int IN_WIDTH = DEF_IN_WIDTH
) (
    input  logic               i_aclk,
    input  logic               i_aresetn,
    input  logic               i_tvalid,
    input  logic [63:0]        i_tdata,
    input  logic               i_tlast,
    input  logic [LOG_LEN-1:0] i_tuser,
    output logic               o_tvalid,
    output logic [31:0]        o_tdata,
    output logic               o_tlast,
    output logic [LOG_LEN-1:0] o_tuser
);

    // |x| of an IN_WIDTH-bit signed value fits in IN_WIDTH-1 bits once the
    // most negative code is clamped.
    localparam int MW = IN_WIDTH - 1;

    function automatic logic [MW-1:0] sat_abs(input logic [IN_WIDTH-1:0] x);
        logic [MW-1:0] neg;
        // Low MW bits of -x; exact for every negative value except the clamped one.
        neg = (~x[MW-1:0]) + MW'(1);
        if (x == {1'b1, {MW{1'b0}}}) return {MW{1'b1}};
        if (x[IN_WIDTH-1])           return neg;
        return x[MW-1:0];
    endfunction

    // Lane bits above IN_WIDTH are only sign extension.
    logic unused_lanes;
    assign unused_lanes = ^{i_tdata[RE_LSB+31:RE_LSB+IN_WIDTH],
                            i_tdata[IM_LSB+31:IM_LSB+IN_WIDTH]};

    logic               v1, v2;
    logic [MW-1:0]      abs_re1, abs_im1;
    logic               last1, last2;
    logic [LOG_LEN-1:0] idx1, idx2;
    logic [MW-1:0]      mx2, mn2;
    logic [IN_WIDTH:0]  sum3;

    assign sum3 = {2'b00, mx2}
                + {4'b0000, mn2[MW-1:2]}
                + {5'b00000, mn2[MW-1:3]};

    // Data stages: no reset needed, qualified by the valid chain.
    always_ff @(posedge i_aclk) begin
        abs_re1 <= sat_abs(i_tdata[RE_LSB +: IN_WIDTH]);
        abs_im1 <= sat_abs(i_tdata[IM_LSB +: IN_WIDTH]);
        last1   <= i_tlast;
        idx1    <= i_tuser;
        mx2     <= (abs_re1 >= abs_im1) ? abs_re1 : abs_im1;
        mn2     <= (abs_re1 >= abs_im1) ? abs_im1 : abs_re1;
        last2   <= last1;
        idx2    <= idx1;
    end

    // Valid chain and output stage are reset.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tuser  <= '0;
        end else begin
            v1       <= i_tvalid;
            v2       <= v1;
            o_tvalid <= v2;
            o_tdata  <= {{(32-IN_WIDTH-1){1'b0}}, sum3};
            o_tlast  <= v2 & last2;
            o_tuser  <= idx2;
        end
    end

endmodule

// File: rtl/fft_mag_peak.sv
// -----------------------------------------------------------------------------
// fft_mag_peak
// Computes a magnitude stream from FFT output beats and reports the peak bin
// of every frame. Peak search covers bins 1..PEAK_HI; the lowest index wins a
// tie. Framing errors (tlast not on the final bin, or final bin without
// tlast) pulse o_frm_err in the same cycle as the offending magnitude beat.
// Ports:
//   i_aclk, i_aresetn  clock, async active-low reset
//   bus                fft_mag_peak_if.slave: FFT stream in, magnitude
//                      stream out, peak report, framing error
//   o_dbg_state        current peak-search state
// -----------------------------------------------------------------------------
module fft_mag_peak
    import fft_mag_peak_pkg::*;
#(
    parameter int LOG_LEN  = DEF_LOG_LEN,
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int PEAK_HI  = DEF_PEAK_HI
) (
    input  logic        i_aclk,
    input  logic        i_aresetn,
    fft_mag_peak_if.slave bus,
    output state_t      o_dbg_state
);

    localparam logic [LOG_LEN-1:0] LAST_IDX  = {LOG_LEN{1'b1}};
    localparam logic [31:0]        PEAK_HI_U = PEAK_HI;

    logic               mag_tvalid;
    logic [31:0]        mag_tdata;
    logic               mag_tlast;
    logic [LOG_LEN-1:0] mag_tuser;

    logic unused_tuser;
    assign unused_tuser = ^bus.i_fft_tuser[23:LOG_LEN];

    fft_mag_est #(
        .LOG_LEN  (LOG_LEN),
        .IN_WIDTH (IN_WIDTH)
    ) u_est (
        .i_aclk    (i_aclk),
        .i_aresetn (i_aresetn),
        .i_tvalid  (bus.i_fft_tvalid),
        .i_tdata   (bus.i_fft_tdata),
        .i_tlast   (bus.i_fft_tlast),
        .i_tuser   (bus.i_fft_tuser[LOG_LEN-1:0]),
        .o_tvalid  (mag_tvalid),
        .o_tdata   (mag_tdata),
        .o_tlast   (mag_tlast),
        .o_tuser   (mag_tuser)
    );

    assign bus.o_mag_tvalid = mag_tvalid;
    assign bus.o_mag_tdata  = mag_tdata;
    assign bus.o_mag_tlast  = mag_tlast;
    assign bus.o_mag_tuser  = mag_tuser;

    state_t             state_q, state_nx;
    logic [31:0]        run_mag_q, base_mag, cand_mag;
    logic [LOG_LEN-1:0] run_bin_q, base_bin, cand_bin;
    logic [31:0]        idx_ext;
    logic               eligible, upd, rep;
    logic               peak_valid_q;
    logic [LOG_LEN-1:0] peak_bin_q;
    logic [31:0]        peak_mag_q;

    assign idx_ext = {{(32-LOG_LEN){1'b0}}, mag_tuser};

    always_comb begin
        state_nx = state_q;
        base_mag = run_mag_q;
        base_bin = run_bin_q;
        // The first beat of a frame compares against a cleared peak, which
        // also makes a tlast followed immediately by a new frame work.
        if (state_q == ST_IDLE) begin
            base_mag = '0;
            base_bin = '0;
        end
        eligible = (idx_ext >= 32'd1) && (idx_ext <= PEAK_HI_U);
        upd      = mag_tvalid && eligible && (mag_tdata > base_mag);
        cand_mag = upd ? mag_tdata : base_mag;
        cand_bin = upd ? mag_tuser : base_bin;
        rep      = mag_tvalid && mag_tlast;
        if (mag_tvalid) begin
            state_nx = mag_tlast ? ST_IDLE : ST_SEARCH;
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q      <= ST_IDLE;
            run_mag_q    <= '0;
            run_bin_q    <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
        end else begin
            state_q      <= state_nx;
            peak_valid_q <= rep;
            if (mag_tvalid) begin
                run_mag_q <= cand_mag;
                run_bin_q <= cand_bin;
            end
            // The report includes any update made by the tlast beat itself.
            if (rep) begin
                peak_bin_q <= cand_bin;
                peak_mag_q <= cand_mag;
            end
        end
    end

    assign bus.o_peak_valid = peak_valid_q;
    assign bus.o_peak_bin   = peak_bin_q;
    assign bus.o_peak_mag   = peak_mag_q;
    assign bus.o_frm_err    = mag_tvalid && (mag_tlast != (mag_tuser == LAST_IDX));
    assign o_dbg_state      = state_q;

endmodule
